// File: rtl/io_responder.sv
// io_responder: peripheral side of the CPU's out/in IO port bus.
// Decodes ioAdrs[3:0]. Reads are served combinationally. Writes take effect
// on the rising edge of ioWe.
// Port map:
//   0x0 STATUS  read : {count[7:0], 4'b0, overflow, busy, full, empty}
//               write: ioOut[3]=1 clears the sticky overflow flag
//   0x1 TXDATA  write: pushes ioOut[7:0] into the TX FIFO. Read returns 0.
//   0x3 GPOUT   read/write GPIO output latch
//   0x4 GPIN    read of the 2-flop synchronized gpIn
//   0x5 TIMER   read counter. Write loads counter and clears prescaler.
//   other       read 0, writes ignored
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   ioAdrs      port address
//   ioOut       write data
//   ioWe        write strobe
//   ioIn        read data
//   txd         8N1 serial output, idle high
//   gpOut       GPIO output latch
//   gpIn        asynchronous GPIO inputs
module io_responder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BAUD_DIV   = 16,
  parameter int unsigned TIMER_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ioAdrs,
  input  logic [15:0] ioOut,
  input  logic        ioWe,
  output logic [15:0] ioIn,
  output logic        txd,
  output logic [15:0] gpOut,
  input  logic [15:0] gpIn
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(BAUD_DIV);
  localparam int unsigned PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;

  // Write strobe edge detect
  logic we_prev;
  logic wr_pulse;
  logic [3:0] addr;

  assign addr     = ioAdrs[3:0];
  assign wr_pulse = ioWe & ~we_prev;

  // Upper address bits are not decoded
  logic unused_adrs_hi;
  assign unused_adrs_hi = ^ioAdrs[7:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) we_prev <= 1'b0;
    else        we_prev <= ioWe;
  end

  // GPIO
  logic [15:0] gp_sync1;
  logic [15:0] gp_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gp_sync1 <= '0;
      gp_sync2 <= '0;
      gpOut    <= '0;
    end else begin
      gp_sync1 <= gpIn;
      gp_sync2 <= gp_sync1;
      if (wr_pulse && addr == 4'h3) gpOut <= ioOut;
    end
  end

  // Timer
  logic [15:0]   timer;
  logic [PW-1:0] presc;
  logic          presc_wrap;

  assign presc_wrap = (presc == PW'(TIMER_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      presc <= '0;
    end else if (wr_pulse && addr == 4'h5) begin
      // A load overrides any increment due in the same cycle
      timer <= ioOut;
      presc <= '0;
    end else if (presc_wrap) begin
      timer <= timer + 16'd1;
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // TX FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          empty;
  logic          full;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          overflow;
  logic [7:0]    head;

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign push_req = wr_pulse && (addr == 4'h1);
  // A push into a full FIFO is dropped even when a pop frees a slot this cycle
  assign push     = push_req && !full;
  assign head     = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (!push && pop) count_next = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ioOut[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push_req && full)
        overflow <= 1'b1;
      else if (wr_pulse && addr == 4'h0 && ioOut[3])
        overflow <= 1'b0;
    end
  end

  // Serializer
  tx_state_t     state;
  tx_state_t     state_next;
  logic [BW-1:0] baud;
  logic [BW-1:0] baud_next;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_next;
  logic [7:0]    shift;
  logic [7:0]    shift_next;
  logic          baud_last;
  logic          busy;

  assign baud_last = (baud == BW'(BAUD_DIV - 1));
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_cnt <= bit_next;
      shift   <= shift_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_cnt;
    shift_next = shift;
    pop        = 1'b0;
    txd        = 1'b1;
    case (state)
      S_IDLE: begin
        txd = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = head;
          baud_next  = '0;
          state_next = S_START;
        end
      end
      S_START: begin
        txd = 1'b0;
        if (baud_last) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = S_DATA;
        end else begin
          baud_next = baud + BW'(1);
        end
      end
      S_DATA: begin
        txd = shift[0];
        if (baud_last) begin
          baud_next  = '0;
          shift_next = {1'b0, shift[7:1]};
          bit_next   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = S_STOP;
        end else begin
          baud_next = baud + BW'(1);
        end
      end
      S_STOP: begin
        txd = 1'b1;
        if (baud_last) begin
          baud_next = '0;
          // Pending data goes straight into the next start bit
          if (!empty) begin
            pop        = 1'b1;
            shift_next = head;
            state_next = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          baud_next = baud + BW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Read mux
  logic [7:0]  count8;
  logic [15:0] status;

  assign count8 = 8'(count);
  assign status = {count8, 4'b0000, overflow, busy, full, empty};

  always_comb begin
    ioIn = '0;
    case (addr)
      4'h0:    ioIn = status;
      4'h3:    ioIn = gpOut;
      4'h4:    ioIn = gp_sync2;
      4'h5:    ioIn = timer;
      default: ioIn = '0;
    endcase
  end

endmodule

// File: tb/tb_io_responder.sv
// Directed testbench for io_responder. It uses BAUD_DIV=4, FIFO_DEPTH=8 and
// TIMER_DIV=1. Bytes sent to TXDATA are queued as expected frames. A serial
// monitor decodes txd and compares each frame against the queue.
module tb_io_responder;

  localparam int unsigned BAUD  = 4;
  localparam int unsigned DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ioAdrs;
  logic [15:0] ioOut;
  logic        ioWe;
  logic [15:0] ioIn;
  logic        txd;
  logic [15:0] gpOut;
  logic [15:0] gpIn;

  int unsigned tests;
  int unsigned fails;
  logic [7:0]  sb[$];
  logic        mon_en;

  io_responder #(
    .FIFO_DEPTH(DEPTH),
    .BAUD_DIV  (BAUD),
    .TIMER_DIV (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ioAdrs(ioAdrs),
    .ioOut (ioOut),
    .ioWe  (ioWe),
    .ioIn  (ioIn),
    .txd   (txd),
    .gpOut (gpOut),
    .gpIn  (gpIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] d);
    ioAdrs = a;
    #1;
    d = ioIn;
  endtask

  // Single-edge write. The caller must leave ioWe low for a cycle before the next one.
  task automatic wr1(input logic [7:0] a, input logic [15:0] d);
    ioAdrs = a;
    ioOut  = d;
    ioWe   = 1'b1;
    cyc(1);
    ioWe   = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    wr1(a, d);
    cyc(1);
  endtask

  task automatic wait_tx_done(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("tx_drain_in_time", {15'd0, (sb.size() == 0)}, 16'd1);
  endtask

  // Serial monitor: decodes 8N1 frames and checks exact bit widths.
  initial begin : monitor
    logic       pending;
    logic       bad;
    logic [7:0] rx;
    logic [7:0] expb;
    pending = 1'b0;
    forever begin
      if (!pending) @(negedge clk);
      pending = 1'b0;
      if (mon_en && rst_n && txd === 1'b0) begin
        bad = 1'b0;
        for (int i = 1; i < BAUD; i++) begin
          @(negedge clk);
          if (txd !== 1'b0) bad = 1'b1;
        end
        for (int b = 0; b < 8; b++) begin
          for (int j = 0; j < BAUD; j++) begin
            @(negedge clk);
            if (j == 0) rx[b] = txd;
            else if (txd !== rx[b]) bad = 1'b1;
          end
        end
        for (int i = 0; i < BAUD; i++) begin
          @(negedge clk);
          if (txd !== 1'b1) bad = 1'b1;
        end
        check("frame_shape", {15'd0, bad}, 16'd0);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL rx_unexpected: observed byte %h expected none", rx);
        end else begin
          expb = sb.pop_front();
          check("rx_byte", {8'd0, rx}, {8'd0, expb});
          if (sb.size() != 0) begin
            @(negedge clk);
            check("b2b_no_gap", {15'd0, txd}, 16'd0);
            pending = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] d;
    tests  = 0;
    fails  = 0;
    mon_en = 1'b1;
    rst_n  = 1'b0;
    ioWe   = 1'b0;
    ioAdrs = '0;
    ioOut  = '0;
    gpIn   = '0;
    cyc(2);
    rd(8'h00, d); check("status_in_reset", d, 16'h0001);
    rst_n = 1'b1;

    // Reset state
    rd(8'h00, d); check("status_reset", d, 16'h0001);
    rd(8'h03, d); check("gpout_reset", d, 16'h0000);
    rd(8'h05, d); check("timer_reset", d, 16'h0000);
    check("txd_reset", {15'd0, txd}, 16'd1);
    cyc(1);
    rd(8'h05, d); check("timer_1", d, 16'h0001);
    cyc(1);
    rd(8'h05, d); check("timer_2", d, 16'h0002);
    rd(8'h02, d); check("port2_zero", d, 16'h0000);
    rd(8'h0A, d); check("portA_zero", d, 16'h0000);

    // Single frame 0xA5
    sb.push_back(8'hA5);
    wr1(8'h01, 16'h00A5);
    rd(8'h00, d); check("status_after_push", d, 16'h0100);
    cyc(1);
    rd(8'h00, d); check("status_popped", d, 16'h0005);
    rd(8'h01, d); check("txdata_read_zero", d, 16'h0000);
    cyc(20);
    rd(8'h00, d); check("busy_mid_frame", {15'd0, d[2]}, 16'd1);
    wait_tx_done(100);
    rd(8'h00, d); check("status_after_frame", d, 16'h0001);

    // ioWe held high: one write with first-cycle data
    ioAdrs = 8'h03;
    ioOut  = 16'h1234;
    ioWe   = 1'b1;
    cyc(1);
    ioOut  = 16'hFFFF;
    cyc(4);
    ioWe   = 1'b0;
    cyc(1);
    check("gpout_held_we", gpOut, 16'h1234);
    rd(8'hF3, d); check("gpout_upper_addr_ignored", d, 16'h1234);
    wr(8'h04, 16'h5555);
    wr(8'h02, 16'h5555);
    check("gpout_other_writes", gpOut, 16'h1234);

    // Burst of 10 bytes: the first pops at once, 8 fill the FIFO, the last is dropped
    for (int k = 0; k < 10; k++) begin
      if (k < DEPTH + 1) sb.push_back(8'h30 + 8'(k));
      wr(8'h01, {8'hEE, 8'h30 + 8'(k)});
    end
    rd(8'h00, d); check("status_full_ovf", d, 16'h080E);
    wr(8'h00, 16'h0000);
    rd(8'h00, d); check("ovf_not_cleared_by_0", d, 16'h080E);
    wr(8'h00, 16'h0008);
    rd(8'h00, d); check("ovf_cleared", d, 16'h0806);
    wait_tx_done(600);
    rd(8'h00, d); check("status_after_burst", d, 16'h0001);

    // Timer wrap and load priority
    wr1(8'h05, 16'hFFFE);
    rd(8'h05, d); check("timer_load", d, 16'hFFFE);
    cyc(1);
    rd(8'h05, d); check("timer_ffff", d, 16'hFFFF);
    cyc(1);
    rd(8'h05, d); check("timer_wrap", d, 16'h0000);

    // GPIN synchronizer latency
    gpIn = 16'hBEEF;
    cyc(1);
    rd(8'h04, d); check("gpin_edge1", d, 16'h0000);
    cyc(1);
    rd(8'h04, d); check("gpin_edge2", d, 16'hBEEF);

    // Reset mid-frame
    mon_en = 1'b0;
    wr(8'h01, 16'h005A);
    wr(8'h01, 16'h003C);
    cyc(8);
    rd(8'h00, d); check("status_pre_reset", d, 16'h0104);
    #2;
    rst_n = 1'b0;
    #1;
    check("txd_async_reset", {15'd0, txd}, 16'd1);
    rd(8'h00, d); check("status_async_reset", d, 16'h0001);
    cyc(2);
    rst_n = 1'b1;
    cyc(30);
    check("txd_idle_after_reset", {15'd0, txd}, 16'd1);
    rd(8'h00, d); check("status_idle_after_reset", d, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
